// File: rtl/c_core_pkg.sv
// Shared constants for the core-library register, mux, adder and counter blocks.
// Pure declarations: no latency, no flow control.
package c_core_pkg;

  localparam int c_set         = 0;
  localparam int c_clear       = 1;
  localparam int c_override    = 0;
  localparam int c_no_override = 1;

  localparam int c_lut_based   = 0;
  localparam int c_buft_based  = 1;

  // Sync controls act regardless of CE under c_override, only with CE under c_no_override.
  function automatic logic c_sync_qualified(input int sync_enable, input logic ce);
    return (sync_enable == c_override) ? 1'b1 : ce;
  endfunction

endpackage

// File: rtl/c_reg_fd.sv
// C_WIDTH-bit register with optional CE, async set/init and sync clear/set/init; Q follows D after 1 edge.
// Always accepts D (no backpressure); async controls override Q immediately and mask clock edges.
module c_reg_fd
  import c_core_pkg::*;
#(
  parameter int                 C_WIDTH         = 2,
  parameter logic [C_WIDTH-1:0] C_AINIT_VAL     = '0,
  parameter logic [C_WIDTH-1:0] C_SINIT_VAL     = '0,
  parameter int                 C_ENABLE_RLOCS  = 1,
  parameter int                 C_HAS_AINIT     = 0,
  parameter int                 C_HAS_ASET      = 0,
  parameter int                 C_HAS_CE        = 0,
  parameter int                 C_HAS_SCLR      = 0,
  parameter int                 C_HAS_SSET      = 0,
  parameter int                 C_HAS_SINIT     = 0,
  parameter int                 C_SYNC_ENABLE   = c_override,
  parameter int                 C_SYNC_PRIORITY = c_clear
) (
  input  logic               CLK,
  input  logic               ACLR_N,
  input  logic [C_WIDTH-1:0] D,
  input  logic               CE,
  input  logic               ASET,
  input  logic               AINIT,
  input  logic               SCLR,
  input  logic               SSET,
  input  logic               SINIT,
  output logic [C_WIDTH-1:0] Q
);

  localparam logic [C_WIDTH-1:0] LP_ONES = '1;

  // Placement hint only; kept as a parameter for drop-in compatibility.
  logic w_unused_rlocs;
  assign w_unused_rlocs = (C_ENABLE_RLOCS != 0);

  logic w_aset;
  logic w_ainit;
  logic w_ce;
  logic w_sclr;
  logic w_sset;
  logic w_sinit;
  logic w_sync_qual;
  logic [C_WIDTH-1:0] w_next;
  logic [C_WIDTH-1:0] r_q = C_AINIT_VAL;

  // Disabled controls are tied off so they can neither act nor wake the register.
  assign w_aset  = (C_HAS_ASET  != 0) ? ASET  : 1'b0;
  assign w_ainit = (C_HAS_AINIT != 0) ? AINIT : 1'b0;
  assign w_ce    = (C_HAS_CE    != 0) ? CE    : 1'b1;
  assign w_sclr  = (C_HAS_SCLR  != 0) ? SCLR  : 1'b0;
  assign w_sset  = (C_HAS_SSET  != 0) ? SSET  : 1'b0;
  assign w_sinit = (C_HAS_SINIT != 0) ? SINIT : 1'b0;

  always_comb begin : sync_next
    w_sync_qual = c_sync_qualified(C_SYNC_ENABLE, w_ce);
    w_next      = r_q;
    if ($isunknown({w_ce, w_sclr, w_sset, w_sinit})) begin
      w_next = 'x;
    end else if (w_sync_qual && w_sinit) begin
      w_next = C_SINIT_VAL;
    end else if (w_sync_qual && w_sclr && w_sset) begin
      w_next = (C_SYNC_PRIORITY == c_clear) ? '0 : LP_ONES;
    end else if (w_sync_qual && w_sclr) begin
      w_next = '0;
    end else if (w_sync_qual && w_sset) begin
      w_next = LP_ONES;
    end else if (w_ce) begin
      w_next = D;
    end
  end

  // A clock edge while an async control is held re-enters the same branch, so Q stays forced.
  always_ff @(posedge CLK or negedge ACLR_N or posedge w_aset or posedge w_ainit) begin
    if (!ACLR_N) begin
      r_q <= '0;
    end else if (w_aset) begin
      r_q <= LP_ONES;
    end else if (w_ainit) begin
      r_q <= C_AINIT_VAL;
    end else begin
      r_q <= w_next;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_c_reg_fd.sv
// Directed bench for c_reg_fd: several configurations share one stimulus stream.
module tb_c_reg_fd;

  logic       clk    = 1'b0;
  logic       aclr_n = 1'b1;
  logic       ce     = 1'b1;
  logic       aset   = 1'b0;
  logic       ainit  = 1'b0;
  logic       sclr   = 1'b0;
  logic       sset   = 1'b0;
  logic       sinit  = 1'b0;
  logic [7:0] d      = 8'h00;

  logic [7:0] q_a, q_b, q_c1, q_c2, q_d1, q_d2, q_e, q_f1, q_f2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  c_reg_fd #(.C_WIDTH(8)) u_a (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_a));

  c_reg_fd #(.C_WIDTH(8), .C_HAS_CE(1)) u_b (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_b));

  c_reg_fd #(.C_WIDTH(8), .C_HAS_SCLR(1), .C_HAS_SSET(1), .C_SYNC_PRIORITY(1)) u_c1 (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_c1));

  c_reg_fd #(.C_WIDTH(8), .C_HAS_SCLR(1), .C_HAS_SSET(1), .C_SYNC_PRIORITY(0)) u_c2 (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_c2));

  c_reg_fd #(.C_WIDTH(8), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_SYNC_ENABLE(0)) u_d1 (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_d1));

  c_reg_fd #(.C_WIDTH(8), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_SYNC_ENABLE(1)) u_d2 (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_d2));

  c_reg_fd #(.C_WIDTH(8), .C_HAS_ASET(1), .C_HAS_AINIT(1), .C_AINIT_VAL(8'h5A)) u_e (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_e));

  c_reg_fd #(.C_WIDTH(8), .C_HAS_SINIT(1), .C_HAS_SCLR(1), .C_SINIT_VAL(8'hC3)) u_f1 (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_f1));

  c_reg_fd #(.C_WIDTH(8), .C_HAS_SINIT(0), .C_HAS_SCLR(1), .C_SINIT_VAL(8'hC3)) u_f2 (
    .CLK(clk), .ACLR_N(aclr_n), .D(d), .CE(ce), .ASET(aset), .AINIT(ainit),
    .SCLR(sclr), .SSET(sset), .SINIT(sinit), .Q(q_f2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("powerup_e", q_e, 8'h5A);
    chk("powerup_a", q_a, 8'h00);

    // Async clear mid-cycle, then first capture.
    aclr_n = 1'b0;
    #1;
    chk("aclr_a", q_a, 8'h00);
    chk("aclr_e", q_e, 8'h00);
    #1;
    aclr_n = 1'b1;
    d = 8'hA5;
    tick();
    chk("cap_a", q_a, 8'hA5);
    chk("cap_b", q_b, 8'hA5);

    // Clock enable.
    ce = 1'b0;
    d  = 8'h3C;
    repeat (3) tick();
    chk("ce0_hold_b", q_b, 8'hA5);
    chk("ce_ignored_a", q_a, 8'h3C);
    ce = 1'b1;
    tick();
    chk("ce1_b", q_b, 8'h3C);

    // SCLR+SSET priority.
    sclr = 1'b1;
    sset = 1'b1;
    d    = 8'h77;
    tick();
    chk("prio_clear_c1", q_c1, 8'h00);
    chk("prio_set_c2", q_c2, 8'hFF);
    chk("sync_ignored_a", q_a, 8'h77);
    sclr = 1'b0;
    sset = 1'b0;

    // Sync-enable override vs no-override.
    d = 8'h66;
    tick();
    chk("load_d1", q_d1, 8'h66);
    ce   = 1'b0;
    sclr = 1'b1;
    tick();
    chk("override_d1", q_d1, 8'h00);
    chk("no_override_d2", q_d2, 8'h66);
    chk("sclr_disabled_b", q_b, 8'h66);
    sclr = 1'b0;
    ce   = 1'b1;

    // Async priority stack and masked clock edges.
    ainit = 1'b1;
    #1;
    chk("ainit_e", q_e, 8'h5A);
    aset = 1'b1;
    #1;
    chk("aset_e", q_e, 8'hFF);
    aclr_n = 1'b0;
    #1;
    chk("aclr_over_e", q_e, 8'h00);
    d = 8'h11;
    tick();
    tick();
    chk("edges_masked_e", q_e, 8'h00);
    chk("edges_masked_a", q_a, 8'h00);
    aset   = 1'b0;
    ainit  = 1'b0;
    aclr_n = 1'b1;
    #1;
    chk("release_keep_e", q_e, 8'h00);
    tick();
    chk("post_release_e", q_e, 8'h11);

    // SINIT beats SCLR; disabled SINIT falls through to SCLR.
    sinit = 1'b1;
    sclr  = 1'b1;
    d     = 8'h99;
    tick();
    chk("sinit_f1", q_f1, 8'hC3);
    chk("sinit_off_f2", q_f2, 8'h00);
    sinit = 1'b0;
    sclr  = 1'b0;
    d     = 8'h42;
    tick();
    chk("resume_f1", q_f1, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
